// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the multiply/divide unit.
//
// Holds the 4-bit MDU Op encoding, the mdu_op_t typedef and the default
// busy-cycle counts. The ALU Op encoding lives in its own package and is
// deliberately kept separate from this one.
//
// Optional feature macro: MDU_MADD_EN (enables Op 6 MADD / Op 7 MSUB in mdu).
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_MULT  = 4'd0,
        MDU_MULTU = 4'd1,
        MDU_DIV   = 4'd2,
        MDU_DIVU  = 4'd3,
        MDU_MTHI  = 4'd4,
        MDU_MTLO  = 4'd5,
        MDU_MADD  = 4'd6,
        MDU_MSUB  = 4'd7
    } mdu_op_t;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_div32.sv
// mdu_div32 -- combinational 32-bit signed/unsigned divider.
//
// Ports:
//   a         in  32  dividend
//   b         in  32  divisor
//   is_signed in  1   1 = two's-complement divide, 0 = unsigned
//   quot      out 32  quotient, truncated toward zero
//   rem       out 32  remainder, sign follows the dividend
//   div_zero  out 1   divisor is zero; quot/rem are then forced to 0
//
// Signed divides run on magnitudes and are sign-corrected afterwards.
// 0x80000000 / -1 falls out naturally: |a| = 0x80000000, |b| = 1, the
// quotient sign is positive and the 32-bit result wraps to 0x80000000.
module mdu_div32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    always_comb begin
        a_neg    = is_signed & a[31];
        b_neg    = is_signed & b[31];
        a_mag    = a_neg ? (32'd0 - a) : a;
        b_mag    = b_neg ? (32'd0 - b) : b;
        div_zero = (b == 32'd0);
        q_mag    = 32'd0;
        r_mag    = 32'd0;
        // Keep the divide operands defined when b is zero.
        if (!div_zero) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem  = a_neg ? (32'd0 - r_mag) : r_mag;
    end

endmodule

// File: rtl/mdu.sv
// mdu -- EX-stage multiply/divide unit holding the architectural HI/LO.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU/MADD/MSUB (>= 1)
//   DIV_CYCLES   busy cycles for DIV/DIVU (>= 1)
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   synchronous active-high reset
//   A      in  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
//   B      in  32  rt operand (divisor / multiplier)
//   Op     in  4   operation select, sampled when Start=1
//   Start  in  1   launch request
//   Busy   out 1   operation in flight (cnt != 0)
//   HI     out 32  HI register
//   LO     out 32  LO register
//
// Optional feature macro: MDU_MADD_EN -- adds Op 6 MADD and Op 7 MSUB,
// accumulating a signed product into {HI,LO}. Undefined: Ops 6-7 ignored.
//
// The result is computed at the Start edge into pending registers and
// committed when the down-counter steps 1 -> 0, so A/B are free to change
// while Busy is high.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  Op,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    // Cleared for divide-by-zero so the commit leaves HI/LO untouched.
    logic             pend_wr_q, pend_wr_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic        div_zero;

    // Low 64 bits of the sign-extended 64x64 product equal the signed 32x32 product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    mdu_div32 u_div (
        .a         (A),
        .b         (B),
        .is_signed (Op == MDU_DIV),
        .quot      (div_quot),
        .rem       (div_rem),
        .div_zero  (div_zero)
    );

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        if (cnt_q != '0) begin
            // In flight: any Start is ignored.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1) && pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (Start) begin
            case (Op)
                MDU_MULT: begin
                    {pend_hi_d, pend_lo_d} = prod_s;
                    pend_wr_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                end
                MDU_MULTU: begin
                    {pend_hi_d, pend_lo_d} = prod_u;
                    pend_wr_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                end
                MDU_DIV, MDU_DIVU: begin
                    pend_hi_d = div_rem;
                    pend_lo_d = div_quot;
                    pend_wr_d = !div_zero;
                    cnt_d     = CNT_W'(DIV_CYCLES);
                end
                MDU_MTHI: hi_d = A;
                MDU_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
                MDU_MADD: begin
                    {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
                    pend_wr_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                end
                MDU_MSUB: begin
                    {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_s;
                    pend_wr_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                end
`endif
                default: ; // invalid Op: no state change
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign Busy = (cnt_q != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- self-checking bench for mdu (MULT_CYCLES=5, DIV_CYCLES=10).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected results are pushed to a scoreboard queue at launch and popped
// when the busy period ends.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [3:0]  Op = 4'd0;
    logic        Start = 1'b0;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int failures = 0;

    // Bench-side architectural HI/LO, used for the "held during Busy" checks.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .Op    (Op),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Launch one op at the current falling edge, wait out Busy (bounded),
    // then compare against the scoreboard. With inject=1 a DIVU Start is
    // attempted in the first busy cycle; it must be ignored.
    task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int exp_cyc, input bit inject);
        exp_t e;
        int   n;
        e.hi = exp_hi; e.lo = exp_lo; e.cyc = exp_cyc;
        sb_q.push_back(e);
        Op = op; A = a; B = b; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        A = $urandom; B = $urandom; // operands must not matter after launch
        n = 0;
        while (Busy && n < 200) begin
            if (n == 0) begin
                chk({name, "_hold_hi"}, HI, m_hi);
                chk({name, "_hold_lo"}, LO, m_lo);
                if (inject) begin
                    Op = MDU_DIVU_C; A = 32'd100; B = 32'd7; Start = 1'b1;
                end
            end else begin
                Start = 1'b0;
                A = $urandom; B = $urandom;
            end
            n++;
            @(negedge clk);
        end
        Start = 1'b0;
        e = sb_q.pop_front();
        chk({name, "_busy_cycles"}, 32'(n), 32'(e.cyc));
        chk({name, "_hi"}, HI, e.hi);
        chk({name, "_lo"}, LO, e.lo);
        $display("txn %-10s op=%0d cycles=%0d HI=0x%08h LO=0x%08h", name, op, n, HI, LO);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    localparam logic [3:0] MDU_DIVU_C = 4'd3;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{4'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        vecs[1]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
        vecs[2]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3]  = '{4'd3, 32'd100,      32'd7,        32'd2,        32'd14,       DC};
        vecs[4]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DC};
        vecs[5]  = '{4'd4, 32'h1234,     32'd0,        32'h1234,     32'h80000000, 0};
        vecs[6]  = '{4'd5, 32'h5678,     32'd0,        32'h1234,     32'h5678,     0};
        vecs[7]  = '{4'd2, 32'd5,        32'd0,        32'h1234,     32'h5678,     DC};
        vecs[8]  = '{4'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, MC};
        vecs[9]  = '{4'd3, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, DC};
        vecs[10] = '{4'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DC};
        vecs[11] = '{4'd8, 32'hDEAD,     32'hBEEF,     32'd1,        32'hFFFFFFFD, 0};

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        reset = 1'b0;

        // Back-to-back: each launch happens in the first Busy=0 cycle.
        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_cyc, 1'b0);
        end

        // Reset on the 3rd busy cycle of MULT 3x4, with a DIVU Start and
        // operand changes in between: nothing is committed.
        Op = 4'd0; A = 32'd3; B = 32'd4; Start = 1'b1;
        @(negedge clk);                                  // busy cycle 1
        Op = MDU_DIVU_C; A = 32'd100; B = 32'd7;         // Start still high
        @(negedge clk);                                  // busy cycle 2
        Start = 1'b0; A = 32'h55; B = 32'h66;
        @(negedge clk);                                  // busy cycle 3
        chk("abort_busy_before", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        $display("txn abort      Busy=%0d HI=0x%08h LO=0x%08h", Busy, HI, LO);
        m_hi = 32'd0; m_lo = 32'd0;

        // Reset wins over a simultaneous Start.
        Op = 4'd4; A = 32'hABCD; Start = 1'b1; reset = 1'b1;
        @(negedge clk);
        Start = 1'b0; reset = 1'b0;
        chk("rst_vs_start_hi", HI, 32'd0);
        chk("rst_vs_start_busy", {31'd0, Busy}, 32'd0);

        // Same MULT without reset: the busy-time DIVU Start is ignored.
        do_op("mult_inj", 4'd0, 32'd3, 32'd4, 32'd0, 32'd12, MC, 1'b1);

`ifdef MDU_MADD_EN
        do_op("mthi0", 4'd4, 32'd0,  32'd0, 32'd0, 32'd12, 0, 1'b0);
        do_op("mtlo10", 4'd5, 32'd10, 32'd0, 32'd0, 32'd10, 0, 1'b0);
        do_op("madd", 4'd6, 32'd2, 32'd3, 32'd0, 32'd16, MC, 1'b0);
        do_op("msub", 4'd7, 32'd4, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFC, MC, 1'b0);
`else
        do_op("op6_inv", 4'd6, 32'd2, 32'd3, 32'd0, 32'd12, 0, 1'b0);
        do_op("op7_inv", 4'd7, 32'd2, 32'd3, 32'd0, 32'd12, 0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the EX stage, alongside the ALU. It takes the same forwarded operands A/B and holds the architectural HI/LO registers. MFHI/MFLO reads are taken directly from the HI/LO outputs into the EX result mux. Busy drives the hazard unit, which stalls any MDU-touching instruction while an operation is in flight.

## Interface
- MULT_CYCLES, 5: Busy cycles for MULT/MULTU (and MADD/MSUB); must be ≥1.
- DIV_CYCLES, 10: Busy cycles for DIV/DIVU; must be ≥1.
- clk  input  1  rising-edge clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO source).
- B  input  32  operand rt (divisor / multiplier).
- Op  input  4  operation select, sampled only when Start=1.
- Start  input  1  launch request, one cycle per instruction.
- Busy  output  1  operation in flight; registered.
- HI  output  32  HI register; registered.
- LO  output  32  LO register; registered.

## Operation
- Op encoding:
  - 0 MULT: {HI,LO} = signed A×B, 64-bit.
  - 1 MULTU: {HI,LO} = unsigned A×B, 64-bit.
  - 2 DIV: LO = quotient, HI = remainder, signed.
  - 3 DIVU: LO = quotient, HI = remainder, unsigned.
  - 4 MTHI: HI = A.
  - 5 MTLO: LO = A.
  - 8–15: invalid.
- Signed divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend (-7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF).
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero (B=0, DIV or DIVU):
  - Full DIV_CYCLES busy period still runs.
  - HI and LO are left unchanged at completion.
- Result capture:
  - The result is computed from A/B at the Start edge and held in internal pending registers.
  - A/B may change during Busy without effect.
- Counter:
  - State is a down-counter `cnt`; Busy = (cnt ≠ 0).
  - Start of a multi-cycle op loads cnt with MULT_CYCLES or DIV_CYCLES.
  - cnt decrements each cycle while nonzero.
  - On the 1→0 transition, pending HI/LO are committed.
- MTHI/MTLO:
  - Write on the Start edge itself.
  - Never assert Busy.
- Ignored Start: any Start while Busy=1, and any Start with an invalid Op, is ignored with no state change. The hazard unit must not issue these, but the MDU tolerates them.
- Reset:
  - Clears HI, LO, cnt, and the pending registers.
  - Reset mid-operation aborts the operation and nothing is committed.
  - Reset wins over a simultaneous Start.

## Timing
- Reset values: Busy=0, HI=0, LO=0.
- Multi-cycle op with Start=1 sampled at edge E0:
  - Busy=1 after E0 through E(N-1), where N = MULT_CYCLES or DIV_CYCLES.
  - At edge EN, HI/LO update and Busy falls in the same edge.
  - New HI/LO are visible from EN, i.e. N cycles after launch.
- MTHI/MTLO at edge E0: new value is visible after E0 (1-cycle latency).
- Back-to-back: Start is accepted in the first cycle Busy=0, including the cycle right after completion, with no bubble.
- HI/LO hold their old values throughout Busy. A stalled MFHI reads the post-commit value once Busy=0.

## Configuration
- MDU_MADD_EN defined:
  - Op 6 MADD: {HI,LO} = {HI,LO} + signed A×B, modulo 2^64.
  - Op 7 MSUB: {HI,LO} = {HI,LO} − signed A×B, modulo 2^64.
  - Both use MULT_CYCLES latency.
  - The accumulator operand is {HI,LO} as sampled at the Start edge.
- MDU_MADD_EN undefined: Ops 6–7 are invalid and ignored like 8–15.

## Structure
- Shared package mdu_pkg holds:
  - The 4-bit Op encoding constants MDU_MULT … MDU_MSUB.
  - A mdu_op_t typedef.
  - Default cycle-count constants.
- The ALU Op encoding stays in its own package and is not merged with mdu_pkg.
- One sub-module, mdu_div32: combinational signed/unsigned 32-bit divider.
  - Handles sign correction, the divide-by-zero flag, and the 0x80000000/−1 case.
  - Top level contains the counter, pending registers, and commit logic.

## Test plan
- Reset, then MULT A=0xFFFFFFFE (−2), B=3:
  - Busy high 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=7 → LO=14, HI=2.
- Preload MTHI 0x1234, MTLO 0x5678 (each visible next cycle), then DIV by B=0:
  - Busy high 10 cycles.
  - Then HI=0x1234, LO=0x5678.
- MULT 3×4; mid-flight, Start DIVU, change A/B, and assert reset on the 3rd Busy cycle:
  - Busy=0, HI=LO=0 next cycle.
  - Repeat without reset: Busy-time Start is ignored and the result is 12.
  - With MDU_MADD_EN: MADD 2×3 on HI:LO=0:10 gives LO=16.
